// File: rtl/core_ctrl_if.sv
// Host-side bundle for the attention-core instruction sequencer: pass control
// inputs plus the registered instruction word and status outputs.
interface core_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int INST_W = 2 * ADDR_W + 9
);
    logic              start;
    logic [ADDR_W:0]   q_cnt;
    logic [ADDR_W:0]   k_cnt;
    logic              readout_en;
    logic              fifo_valid;
    logic [INST_W-1:0] inst;
    logic              out_valid;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, q_cnt, k_cnt, readout_en, fifo_valid,
        input  inst, out_valid, busy, done, err
    );

    modport slave (
        input  start, q_cnt, k_cnt, readout_en, fifo_valid,
        output inst, out_valid, busy, done, err
    );
endinterface

// File: rtl/core_ctrl.sv
// Autonomous Q.K pass sequencer: K load, settle gap, Q execute, FIFO drain to
// psum memory and optional psum readout, emitting one registered inst per cycle.
module core_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int GAP      = 10,
    parameter int DRAIN_TO = 64
) (
    input  logic        clk,
    input  logic        reset,
    core_ctrl_if.slave  ctrl
);
    localparam int INST_W = 2 * ADDR_W + 9;
    localparam int CW     = ADDR_W + 1;
    localparam int TW     = $clog2(((GAP > DRAIN_TO) ? GAP : DRAIN_TO) + 1);
    localparam logic [CW-1:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [TW-1:0] GAP_T  = TW'(GAP);
    localparam logic [TW-1:0] TO_T   = TW'(DRAIN_TO);

    typedef enum logic [2:0] {
        S_IDLE, S_KLOAD, S_GAP, S_EXEC, S_DRAIN, S_READOUT, S_DONE
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [TW-1:0]     tmr_q;
    logic [CW-1:0]     qn_q;
    logic [CW-1:0]     kn_q;
    logic              ro_q;
    logic [INST_W-1:0] inst_q;
    logic              ov_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    function automatic logic cnt_ok(input logic [CW-1:0] n);
        return (n != '0) && (n <= DEPTH);
    endfunction

    // Write-enable bits of qmem/kmem are hard-wired low.
    function automatic logic [INST_W-1:0] word(
        input logic              pop,
        input logic [ADDR_W-1:0] qk,
        input logic [ADDR_W-1:0] pm,
        input logic              ex,
        input logic              ld,
        input logic              qrd,
        input logic              krd,
        input logic              prd,
        input logic              pwr
    );
        return {pop, qk, pm, ex, ld, qrd, 1'b0, krd, 1'b0, prd, pwr};
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tmr_q   <= '0;
            qn_q    <= '0;
            kn_q    <= '0;
            ro_q    <= 1'b0;
            inst_q  <= '0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            inst_q <= '0;
            ov_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ctrl.start) begin
                        busy_q <= 1'b1;
                        cnt_q  <= '0;
                        tmr_q  <= '0;
                        qn_q   <= ctrl.q_cnt;
                        kn_q   <= ctrl.k_cnt;
                        ro_q   <= ctrl.readout_en;
                        if (cnt_ok(ctrl.q_cnt) && cnt_ok(ctrl.k_cnt)) begin
                            err_q   <= 1'b0;
                            state_q <= S_KLOAD;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                // Read row i while loading the row read one cycle earlier.
                S_KLOAD: begin
                    inst_q <= word(1'b0, (cnt_q < kn_q) ? cnt_q[ADDR_W-1:0] : '0, '0,
                                   1'b0, cnt_q != '0, 1'b0, cnt_q < kn_q, 1'b0, 1'b0);
                    if (cnt_q == kn_q) begin
                        cnt_q   <= '0;
                        state_q <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_GAP: begin
                    if (tmr_q + TW'(1) >= GAP_T) begin
                        tmr_q   <= '0;
                        state_q <= S_EXEC;
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                S_EXEC: begin
                    inst_q <= word(1'b0, (cnt_q < qn_q) ? cnt_q[ADDR_W-1:0] : '0, '0,
                                   cnt_q != '0, 1'b0, cnt_q < qn_q, 1'b0, 1'b0, 1'b0);
                    if (cnt_q == qn_q) begin
                        cnt_q   <= '0;
                        tmr_q   <= '0;
                        state_q <= S_DRAIN;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                // Pop and psum write share one word; tmr_q counts idle cycles since last pop.
                S_DRAIN: begin
                    if (ctrl.fifo_valid) begin
                        inst_q <= word(1'b1, '0, cnt_q[ADDR_W-1:0],
                                       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                        tmr_q  <= '0;
                        if (cnt_q + CW'(1) == qn_q) begin
                            cnt_q   <= '0;
                            state_q <= ro_q ? S_READOUT : S_DONE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                        if (tmr_q + TW'(1) == TO_T) begin
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_READOUT: begin
                    inst_q <= word(1'b0, '0, (cnt_q < qn_q) ? cnt_q[ADDR_W-1:0] : '0,
                                   1'b0, 1'b0, 1'b0, 1'b0, cnt_q < qn_q, 1'b0);
                    ov_q   <= (cnt_q != '0);
                    if (cnt_q == qn_q) begin
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ctrl.inst      = inst_q;
    assign ctrl.out_valid = ov_q;
    assign ctrl.busy      = busy_q;
    assign ctrl.done      = done_q;
    assign ctrl.err       = err_q;
endmodule
